uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a parallel byte with a valid strobe and latches it with the parity configuration. It then walks the frame states START, DATA, PARITY and STOP, driving the 2-bit line-select, serial data bit, parity bit and busy flag into the registered TX output mux. Each `clk` cycle is one bit time: `clk` is the baud-rate clock.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame, at least 2.
- `clk`  in  1: baud-rate clock. All logic runs on its rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `p_data`  in  DATA_WIDTH: parallel payload. Sampled only on accept.
- `data_valid`  in  1: payload-valid request.
- `par_en`  in  1: parity enable. Sampled on accept.
- `par_typ`  in  1: parity type, 0 = even, 1 = odd. Sampled on accept.
- `sel`  out  2: line select to the mux. 00 = idle/stop (1), 01 = start (0), 10 = ser_data, 11 = par_bit.
- `ser_data`  out  1: current payload bit, LSB first.
- `par_bit`  out  1: parity bit for the latched frame.
- `busy`  out  1: high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Registered state. `sel` and `busy` are decoded from the state only.
  - IDLE: `sel`=00, `busy`=0.
  - START: `sel`=01.
  - DATA: `sel`=10.
  - PARITY: `sel`=11.
  - STOP: `sel`=00.
  - `busy`=1 in every state except IDLE.
- Accept condition: `data_valid`=1 while state is IDLE or STOP.
  - On accept, register `p_data` into the shift register, and register `par_en`, `par_typ` and the computed parity.
  - Next state is START.
- `data_valid` in START, DATA or PARITY is ignored. No queuing, no error flag.
- Transitions:
  - IDLE→START on accept.
  - START→DATA always.
  - DATA stays for DATA_WIDTH cycles; a bit counter of width $clog2(DATA_WIDTH) runs from 0 to DATA_WIDTH-1.
  - On the last DATA cycle: →PARITY if latched `par_en`=1, else →STOP.
  - PARITY→STOP always.
  - STOP→START on accept (back-to-back), else →IDLE.
- `ser_data` = shift_reg[0]. The shift register shifts right by one at the end of each DATA cycle and is zero-filled.
- Parity:
  - `par_bit` = XOR-reduce(latched data) XOR latched `par_typ`.
  - Held stable from accept until the next accept.
- Frame length: 1 + DATA_WIDTH + `par_en` + 1 cycles.
- Reset values (rst=0 at a rising edge): state IDLE, `sel`=00, `busy`=0, `ser_data`=0, `par_bit`=0, counter 0, shift register 0.
  - Reset mid-frame aborts the frame immediately, with no completion of the stop bit.
  - `data_valid` is ignored on the reset cycle.

## Timing
- Accept at edge N: `sel`=01 and `busy`=1 from edge N.
- Payload bit k is on `ser_data` with `sel`=10 during cycle N+1+k.
- Parity follows at N+1+DATA_WIDTH when enabled. Stop follows after that.
- The mux adds one register stage, so the line shows each bit one cycle later than `sel`.
- Back-to-back frames: STOP lasts exactly one cycle and `busy` never drops.
- `data_valid` must be held until `busy` is observed as 0, or until the STOP cycle. It is level-sampled, not edge-detected.
- A `data_valid` held high continuously produces frames back-to-back with the same payload.

## Structure
- Shared package `uart_tx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - `sel` encodings SEL_IDLE_STOP=2'b00, SEL_START=2'b01, SEL_DATA=2'b10, SEL_PARITY=2'b11;
  - PAR_EVEN=0 and PAR_ODD=1.
- One sub-module: `uart_parity_calc`, combinational, with inputs DATA_WIDTH data and `par_typ`, output parity. It is instanced once at the accept path.
- The rest is a single module: FSM, bit counter, shift register.

## Test plan
- Even parity, `p_data`=8'hA5, `par_en`=1, `par_typ`=0:
  - `sel` sequence 01, 10×8, 11, 00 over 11 cycles.
  - `ser_data` 1,0,1,0,0,1,0,1.
  - `par_bit`=0.
  - `busy` high for 11 cycles, then 0.
- Odd and even parity on 8'h01:
  - `par_typ`=1 gives `par_bit`=0.
  - `par_typ`=0 gives `par_bit`=1.
- `par_en`=0 on 8'hFF: frame of 10 cycles, no `sel`=11 cycle, `ser_data` 1×8.
- Back-to-back: `data_valid` held, 8'h3C then 8'hC3 presented in STOP.
  - Second START immediately after the single STOP cycle.
  - `busy` stays 1 throughout.
  - Second payload 1,1,0,0,0,0,1,1.
- `data_valid` pulsed with 8'h00 during DATA bit 3 of an 8'hA5 frame: ignored; the frame completes unchanged.
- `rst`=0 during DATA bit 4:
  - next edge gives `sel`=00, `busy`=0, `ser_data`=0, `par_bit`=0;
  - after release, a new 8'h5A frame is correct from START.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared frame-state, line-select and parity-type definitions for the UART TX path.
// Rev 1.0
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] SEL_IDLE_STOP = 2'b00;
  localparam logic [1:0] SEL_START     = 2'b01;
  localparam logic [1:0] SEL_DATA      = 2'b10;
  localparam logic [1:0] SEL_PARITY    = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity of a payload word; par_typ=1 inverts to odd parity.
// Rev 1.0
`default_nettype none

module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  assign o_parity = (^i_data) ^ i_par_typ;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer (START, DATA, optional PARITY, STOP), one bit per clk.
// Rev 1.0
`default_nettype none

module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int              CW     = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  tx_state_t               r_state;
  tx_state_t               w_state_nxt;
  logic                    w_accept;
  logic                    w_last_bit;
  logic                    w_par;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par_en;
  logic                    r_par;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .i_data    (p_data),
    .i_par_typ (par_typ),
    .o_parity  (w_par)
  );

  assign w_last_bit = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accept is only possible in IDLE or STOP; STOP accepting gives back-to-back frames.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    sel         = SEL_IDLE_STOP;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        sel         = SEL_START;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        sel = SEL_DATA;
        if (w_last_bit) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        sel         = SEL_PARITY;
        w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
    end else if (w_accept) begin
      r_shift  <= p_data;
      r_cnt    <= '0;
      r_par_en <= par_en;
      r_par    <= w_par;
    end else if (r_state == ST_DATA) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= w_last_bit ? '0 : r_cnt + C_ONE;
    end
  end

  assign ser_data = r_shift[0];
  assign par_bit  = r_par;

endmodule

`default_nettype wire
